// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial ALU controller.
`timescale 1ns/1ps
package nsa_pkg;

  // Controller states: waiting, sequencing nibbles, result-valid pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  // Width of the shared adder slice.
  localparam int unsigned NIBBLE = 4;

endpackage

// File: rtl/nibble_adder.sv
// 4-bit ripple-carry adder slice; exposes the carry into bit 3 for overflow detection.
`timescale 1ns/1ps
module nibble_adder
  import nsa_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] sum,
  output logic              c3,
  output logic              cout
);

  logic [NIBBLE:0] carry_c;

  // Ripple the carry through the four bit positions.
  always_comb begin
    carry_c    = '0;
    sum        = '0;
    carry_c[0] = cin;
    for (int i = 0; i < int'(NIBBLE); i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_c[i];
      carry_c[i+1] = (a[i] & b[i]) | (carry_c[i] & (a[i] ^ b[i]));
    end
  end

  assign c3   = carry_c[NIBBLE-1];
  assign cout = carry_c[NIBBLE];

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract built from one shared 4-bit adder slice,
// processing one nibble per cycle, least-significant first.
// Optional zero-result flag is enabled by defining NSA_ZERO_FLAG_EN.
`timescale 1ns/1ps
module nibble_serial_alu_ctrl
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef NSA_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             overflow
);

  localparam int unsigned N     = WIDTH / NIBBLE;
  localparam int unsigned CNT_W = $clog2(N);

  // Reject widths the nibble sequencer cannot handle.
  generate
    if (((WIDTH % NIBBLE) != 0) || (WIDTH < 8)) begin : g_bad_width
      $error("nibble_serial_alu_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  nsa_state_t        state;
  logic [WIDTH-1:0]  a_sr;
  logic [WIDTH-1:0]  b_sr;
  logic              carry;
  logic [CNT_W-1:0]  idx;

  logic [NIBBLE-1:0] slice_sum;
  logic              slice_c3;
  logic              slice_cout;
  logic              last_nibble;

`ifdef NSA_ZERO_FLAG_EN
  logic              zero_acc;
`endif

  // The single shared slice always works on the low nibble of the shift registers.
  nibble_adder u_adder (
    .a    (a_sr[NIBBLE-1:0]),
    .b    (b_sr[NIBBLE-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .c3   (slice_c3),
    .cout (slice_cout)
  );

  assign last_nibble = (idx == CNT_W'(N - 1));

  // Sequencer: accept operands, walk the nibbles, pulse done and hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
`ifdef NSA_ZERO_FLAG_EN
      zero     <= 1'b0;
      zero_acc <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + 1: the +1 enters as the initial carry.
            a_sr     <= a;
            b_sr     <= sub ? ~b : b;
            carry    <= sub;
            idx      <= '0;
            busy     <= 1'b1;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
`ifdef NSA_ZERO_FLAG_EN
            zero     <= 1'b0;
            zero_acc <= 1'b1;
`endif
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result[NIBBLE * 32'(idx) +: NIBBLE] <= slice_sum;
          a_sr  <= {{NIBBLE{1'b0}}, a_sr[WIDTH-1:NIBBLE]};
          b_sr  <= {{NIBBLE{1'b0}}, b_sr[WIDTH-1:NIBBLE]};
          idx   <= idx + CNT_W'(1);
          carry <= slice_cout;
`ifdef NSA_ZERO_FLAG_EN
          zero_acc <= zero_acc & (slice_sum == '0);
`endif
          if (last_nibble) begin
            cout     <= slice_cout;
            overflow <= slice_cout ^ slice_c3;
            busy     <= 1'b0;
            done     <= 1'b1;
`ifdef NSA_ZERO_FLAG_EN
            zero     <= zero_acc & (slice_sum == '0);
`endif
            state    <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Scoreboard bench for nibble_serial_alu_ctrl (WIDTH=32).
`timescale 1ns/1ps
module tb_nibble_serial_alu_ctrl;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;

  typedef struct {
    logic [31:0] res;
    logic        co;
    logic        ovf;
    logic        zf;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        overflow;
  logic        zero;

  exp_t        sb[$];
  mstate_t     m_state = M_IDLE;
  int          m_cnt = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_res = '0;
  logic        last_co = 1'b0;
  logic        last_ovf = 1'b0;
  logic        last_zf = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  nibble_serial_alu_ctrl #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
`ifdef NSA_ZERO_FLAG_EN
    .zero     (zero),
`endif
    .overflow (overflow)
  );

`ifndef NSA_ZERO_FLAG_EN
  assign zero = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference arithmetic, written with a wide add and a sign-based overflow rule.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    exp_t        e;
    logic [31:0] bx;
    logic [32:0] s;
    bx      = sv ? ~bv : bv;
    s       = {1'b0, av} + {1'b0, bx} + 33'(sv);
    e.res   = s[31:0];
    e.co    = s[32];
    e.ovf   = (av[31] == bx[31]) && (e.res[31] != av[31]);
    e.zf    = (e.res == 32'd0);
    e.done_cyc = 0;
    return e;
  endfunction

  // One clock: drive inputs, advance the bench's model of the controller at the edge.
  task automatic step(input logic s, input logic [31:0] av, input logic [31:0] bv, input logic sv);
    exp_t e;
    start = s;
    a     = av;
    b     = bv;
    sub   = sv;
    @(posedge clk);
    cyc++;
    if (rst) begin
      if (m_state == M_RUN && sb.size() > 0) void'(sb.pop_back());
      m_state  = M_IDLE;
      m_cnt    = 0;
      last_res = '0;
      last_co  = 1'b0;
      last_ovf = 1'b0;
      last_zf  = 1'b0;
    end else begin
      case (m_state)
        M_IDLE, M_DONE: begin
          if (s) begin
            e = model(av, bv, sv);
            e.done_cyc = cyc + 8;
            sb.push_back(e);
            m_state = M_RUN;
            m_cnt   = 0;
          end else begin
            m_state = M_IDLE;
          end
        end
        default: begin
          m_cnt++;
          if (m_cnt == 8) m_state = M_DONE;
        end
      endcase
    end
    #1;
  endtask

  task automatic op(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    step(1'b1, av, bv, sv);
    for (int i = 0; i < 20 && m_state != M_IDLE; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  // Output monitor: handshake levels every cycle, scoreboard pop on done, hold check in idle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("busy", 64'(busy), 64'(m_state == M_RUN));
      check("done", 64'(done), 64'(m_state == M_DONE));
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("result", 64'(result), 64'(e.res));
          check("cout", 64'(cout), 64'(e.co));
          check("overflow", 64'(overflow), 64'(e.ovf));
`ifdef NSA_ZERO_FLAG_EN
          check("zero", 64'(zero), 64'(e.zf));
`endif
          check("latency", 64'(cyc), 64'(e.done_cyc));
          last_res = e.res;
          last_co  = e.co;
          last_ovf = e.ovf;
          last_zf  = e.zf;
        end
      end else if (m_state == M_IDLE) begin
        check("hold_result", 64'(result), 64'(last_res));
        check("hold_cout", 64'(cout), 64'(last_co));
        check("hold_overflow", 64'(overflow), 64'(last_ovf));
`ifdef NSA_ZERO_FLAG_EN
        check("hold_zero", 64'(zero), 64'(last_zf));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1;
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    mon_en = 1'b1;
    rst = 1'b0;
    step(1'b0, '0, '0, 1'b0);

    // Abort a running operation with reset at the third processing edge.
    step(1'b1, 32'h1234_5678, 32'h0000_0001, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    step(1'b0, '0, '0, 1'b0);
    check("abort_result", 64'(result), 64'(0));
    rst = 1'b0;
    repeat (12) step(1'b0, '0, '0, 1'b0);

    // Directed arithmetic cases.
    op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    op(32'h0000_0005, 32'h0000_0007, 1'b1);
    op(32'h8000_0000, 32'h0000_0001, 1'b1);
    op(32'h0000_0000, 32'h0000_0000, 1'b1);
    op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    op(32'h8000_0000, 32'h8000_0000, 1'b0);

    // Start held high with operands changing every cycle.
    for (int i = 0; i < 60; i++) step(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20 && m_state != M_IDLE; i++) step(1'b0, '0, '0, 1'b0);

    // A few isolated random operations.
    for (int i = 0; i < 6; i++) op($urandom, $urandom, 1'($urandom_range(0, 1)));

    repeat (3) step(1'b0, '0, '0, 1'b0);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
